// File: rtl/sdram_phase_pkg.sv
// Shared definitions for the SDRAM read-capture phase calibration controller:
// FSM states, sdram_phase command codes, ph_err status codes and failure codes.
package sdram_phase_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RSTDCM,
    ST_SETTLE,
    ST_CLEAR,
    ST_READ,
    ST_DRAIN,
    ST_EVAL,
    ST_STEP,
    ST_QUAD,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  localparam logic [3:0] PH_CMD_CLR    = 4'h0;
  localparam logic [3:0] PH_CMD_INC    = 4'h1;
  localparam logic [3:0] PH_CMD_DEC    = 4'h2;
  localparam logic [3:0] PH_CMD_RST    = 4'h3;
  localparam logic [3:0] PH_CMD_Q90INC = 4'h4;
  localparam logic [3:0] PH_CMD_Q90RST = 4'hC;

  localparam logic [1:0] PH_ERR_NONE  = 2'd0;
  localparam logic [1:0] PH_ERR_LATE  = 2'd1;
  localparam logic [1:0] PH_ERR_EARLY = 2'd2;
  localparam logic [1:0] PH_ERR_EDGE  = 2'd3;

  localparam logic [1:0] FAIL_NONE   = 2'd0;
  localparam logic [1:0] FAIL_NODATA = 2'd1;
  localparam logic [1:0] FAIL_RANGE  = 2'd2;

  // Depth of the ph_err pipeline inside sdram_phase.
  localparam int DRAIN_CYCLES = 4;

  // Width of a down-counter that must hold (largest count - 1).
  function automatic int cal_cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_phase_cal_cnt.sv
// Loadable down-counter shared by the settle, read-count and drain phases of
// the calibration FSM. o_zero is high whenever the count has reached zero.
module sdram_phase_cal_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdram_phase_cal.sv
// Closed-loop DQS capture phase calibration driving sdram_phase commands.
// Optional quadrant search is enabled by defining SDRAM_PHASE_CAL_QUAD_EN.
module sdram_phase_cal
  import sdram_phase_pkg::*;
#(
  parameter int MAX_STEPS      = 64,
  parameter int SETTLE_CYCLES  = 32,
  parameter int READS_PER_STEP = 4
) (
  input  logic       sclk0,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ph_err,
  input  logic       rd_done,
  output logic       rd_req,
  output logic       pre_wcmd,
  output logic [3:0] wd,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [7:0] phase_ofs,
  output logic [1:0] quad
);

  localparam int CNT_W = cal_cnt_width(SETTLE_CYCLES, READS_PER_STEP, DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] P_SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_READS_LD  = CNT_W'(READS_PER_STEP - 1);
  localparam logic [CNT_W-1:0] P_DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic signed [7:0] P_MAX_POS  = 8'(MAX_STEPS);
  localparam logic signed [7:0] P_MAX_NEG  = -P_MAX_POS;

  cal_state_e         r_state;
  logic               r_rd_req;
  logic               r_pre_wcmd;
  logic [3:0]         r_wd;
  logic               r_busy;
  logic               r_done;
  logic               r_fail;
  logic [1:0]         r_fail_code;
  logic signed [7:0]  r_phase_ofs;
  logic [1:0]         r_quad;
  logic               r_dir_vld;
  logic               r_dir_inc;

  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_val;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic               w_tgt_inc;
  logic               w_at_limit;

  sdram_phase_cal_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .i_clk      (sclk0),
    .i_rst      (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // The counter is loaded on the cycle that leaves for the counted state.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_RSTDCM: begin
        w_cnt_load = !r_pre_wcmd;
        w_cnt_val  = P_SETTLE_LD;
      end
      ST_STEP: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = P_SETTLE_LD;
      end
      ST_CLEAR: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = P_READS_LD;
      end
      ST_SETTLE, ST_DRAIN: w_cnt_dec = !w_cnt_zero;
      ST_READ: begin
        if (rd_done) begin
          w_cnt_load = w_cnt_zero;
          w_cnt_val  = P_DRAIN_LD;
          w_cnt_dec  = !w_cnt_zero;
        end
      end
      default: ;
    endcase
  end

  assign w_tgt_inc  = (ph_err == PH_ERR_EARLY);
  assign w_at_limit = w_tgt_inc ? (r_phase_ofs >= P_MAX_POS) : (r_phase_ofs <= P_MAX_NEG);

  always_ff @(posedge sclk0) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_req    <= 1'b0;
      r_pre_wcmd  <= 1'b0;
      r_wd        <= PH_CMD_CLR;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= FAIL_NONE;
      r_phase_ofs <= '0;
      r_quad      <= 2'd0;
      r_dir_vld   <= 1'b0;
      r_dir_inc   <= 1'b0;
    end else begin
      r_pre_wcmd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= FAIL_NONE;
            r_busy      <= 1'b1;
            r_dir_vld   <= 1'b0;
`ifdef SDRAM_PHASE_CAL_QUAD_EN
            r_pre_wcmd  <= 1'b1;
            r_wd        <= PH_CMD_Q90RST;
            r_quad      <= 2'd0;
`endif
            r_state     <= ST_RSTDCM;
          end
        end
        // Holds for one idle cycle when entered straight from a command strobe.
        ST_RSTDCM: begin
          if (!r_pre_wcmd) begin
            r_pre_wcmd  <= 1'b1;
            r_wd        <= PH_CMD_RST;
            r_phase_ofs <= '0;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_pre_wcmd <= 1'b1;
          r_wd       <= PH_CMD_CLR;
          r_rd_req   <= 1'b1;
          r_state    <= ST_READ;
        end
        ST_READ: begin
          if (rd_done && w_cnt_zero) begin
            r_rd_req <= 1'b0;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_cnt_zero) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (ph_err == PH_ERR_EDGE) begin
            r_state <= ST_DONE;
          end else if (ph_err == PH_ERR_NONE) begin
            r_fail_code <= FAIL_NODATA;
            r_state     <= ST_FAIL;
          end else if (r_dir_vld && (r_dir_inc != w_tgt_inc)) begin
            r_state <= ST_DONE;
          end else if (w_at_limit) begin
            r_state <= ST_QUAD;
          end else begin
            r_dir_inc <= w_tgt_inc;
            r_state   <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_pre_wcmd  <= 1'b1;
          r_wd        <= r_dir_inc ? PH_CMD_INC : PH_CMD_DEC;
          r_phase_ofs <= r_dir_inc ? (r_phase_ofs + 8'sd1) : (r_phase_ofs - 8'sd1);
          r_dir_vld   <= 1'b1;
          r_state     <= ST_SETTLE;
        end
        ST_QUAD: begin
`ifdef SDRAM_PHASE_CAL_QUAD_EN
          if (r_quad == 2'd3) begin
            r_fail_code <= FAIL_RANGE;
            r_state     <= ST_FAIL;
          end else begin
            r_pre_wcmd <= 1'b1;
            r_wd       <= PH_CMD_Q90INC;
            r_quad     <= r_quad + 2'd1;
            r_dir_vld  <= 1'b0;
            r_state    <= ST_RSTDCM;
          end
`else
          r_fail_code <= FAIL_RANGE;
          r_state     <= ST_FAIL;
`endif
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_fail  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_req    = r_rd_req;
  assign pre_wcmd  = r_pre_wcmd;
  assign wd        = r_wd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign phase_ofs = r_phase_ofs;
  assign quad      = r_quad;

endmodule

// File: tb/tb_sdram_phase_cal.sv
// Bench for sdram_phase_cal: phase-detector/arbiter model, per-cycle checker
// and directed calibration scenarios with hand-derived end results.
module tb_sdram_phase_cal;

  localparam int MAX_STEPS      = 6;
  localparam int SETTLE_CYCLES  = 5;
  localparam int READS_PER_STEP = 3;
  localparam int TIMEOUT        = 5000;

  logic       sclk0 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ph_err = 2'd0;
  logic       rd_done = 1'b0;
  logic       rd_req;
  logic       pre_wcmd;
  logic [3:0] wd;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] fail_code;
  logic [7:0] phase_ofs;
  logic [1:0] quad;

  always #5 sclk0 = ~sclk0;

  sdram_phase_cal #(
    .MAX_STEPS      (MAX_STEPS),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .READS_PER_STEP (READS_PER_STEP)
  ) u_dut (
    .sclk0     (sclk0),
    .rst       (rst),
    .start     (start),
    .ph_err    (ph_err),
    .rd_done   (rd_done),
    .rd_req    (rd_req),
    .pre_wcmd  (pre_wcmd),
    .wd        (wd),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_code (fail_code),
    .phase_ofs (phase_ofs),
    .quad      (quad)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_ofs = 0;
  int m_quad = 0;
  int cmd_cnt [16];
  int pulses = 0;
  bit prev_rd_req = 1'b0;
  bit prev_pre = 1'b0;
  int scen = 0;
  bit spur_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Phase detector seen through the DCM: result depends on the commanded offset.
  function automatic logic [1:0] model_err(input int sc, input int ofs);
    case (sc)
      1: return (ofs > -5) ? 2'd1 : 2'd2;
      2: return (ofs == 3) ? 2'd3 : 2'd2;
      3: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Detector and arbiter stimulus, updated away from the active edge.
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(negedge sclk0);
      ph_err = model_err(scen, m_ofs);
      if (rd_req) begin
        gap++;
        rd_done = (gap % 3 == 0);
      end else begin
        gap = 0;
        rd_done = spur_en && (cyc % 4 == 0);
      end
    end
  end

  // Per-cycle checker, sampled 1 time unit after each rising edge.
  always @(posedge sclk0) begin
    bit legal;
    #1;
    cyc++;
    if (rst) begin
      check("reset_outputs", {rd_req, pre_wcmd, busy, done, fail, wd, fail_code, phase_ofs, quad}, 0);
      m_ofs = 0;
      m_quad = 0;
      pulses = 0;
      prev_rd_req = 1'b0;
      prev_pre = 1'b0;
    end else begin
      if (pre_wcmd) begin
        cmd_cnt[wd]++;
        legal = 1'b1;
        case (wd)
          4'h0: ;
          4'h1: m_ofs++;
          4'h2: m_ofs--;
          4'h3: m_ofs = 0;
          4'h4: m_quad = (m_quad + 1) % 4;
          4'hC: m_quad = 0;
          default: legal = 1'b0;
        endcase
        check("wd_legal", legal, 1);
`ifndef SDRAM_PHASE_CAL_QUAD_EN
        check("no_quad_cmd", (wd == 4'h4) || (wd == 4'hC), 0);
`endif
        check("cmd_spacing", prev_pre, 0);
      end
      check("phase_ofs", $signed(phase_ofs), m_ofs);
      check("quad", quad, m_quad);
      check("ofs_range", ($signed(phase_ofs) <= MAX_STEPS) && ($signed(phase_ofs) >= -MAX_STEPS), 1);
      check("flag_excl", (busy && (done || fail)) || (done && fail), 0);
      if (prev_rd_req && rd_done) pulses++;
      if (prev_rd_req && !rd_req) begin
        check("rd_req_pulses", pulses, READS_PER_STEP);
        check("rd_req_drop_timing", rd_done, 1);
        pulses = 0;
      end
      prev_rd_req = rd_req;
      prev_pre = pre_wcmd;
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 16; i++) cmd_cnt[i] = 0;
  endtask

  // Starts a calibration; optionally re-pulses start after extra_at cycles.
  task automatic run(input int sc, input int extra_at);
    int n;
    @(negedge sclk0);
    scen = sc;
    clear_counts();
    start = 1'b1;
    @(negedge sclk0);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("flags_cleared", {done, fail, fail_code}, 0);
`ifdef SDRAM_PHASE_CAL_QUAD_EN
    check("start_to_q90rst", {pre_wcmd, wd}, {1'b1, 4'hC});
`else
    check("start_no_cmd", pre_wcmd, 0);
`endif
    n = 0;
    while (busy && n < TIMEOUT) begin
      @(negedge sclk0);
      n++;
      if (n == extra_at) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    check("run_timeout", busy, 0);
  endtask

  initial begin
    int n;
    int total;
    clear_counts();
    repeat (3) @(negedge sclk0);
    rst = 1'b0;
    repeat (2) @(negedge sclk0);
    check("idle_after_reset", {busy, done, fail, rd_req}, 0);

    // Late until -5, early beyond: five decrements then lock at the crossing.
    run(1, 0);
    check("s1_done", done, 1);
    check("s1_fail", fail, 0);
    check("s1_ofs", $signed(phase_ofs), -5);
    check("s1_quad", quad, 0);
    check("s1_dec_cmds", cmd_cnt[2], 5);
    check("s1_inc_cmds", cmd_cnt[1], 0);
    check("s1_clr_cmds", cmd_cnt[0], 6);
    check("s1_rst_cmds", cmd_cnt[3], 1);
    repeat (10) @(negedge sclk0);
    check("s1_done_sticky", done, 1);

    // Edge found at +3, with a dropped start mid-run and stray rd_done pulses.
    spur_en = 1'b1;
    run(2, 30);
    spur_en = 1'b0;
    check("s2_done", done, 1);
    check("s2_ofs", $signed(phase_ofs), 3);
    check("s2_inc_cmds", cmd_cnt[1], 3);
    check("s2_dec_cmds", cmd_cnt[2], 0);
    check("s2_clr_cmds", cmd_cnt[0], 4);

    // Always early: range exhausted.
    run(3, 0);
    check("s3_fail", fail, 1);
    check("s3_done", done, 0);
    check("s3_fail_code", fail_code, 2);
    check("s3_ofs", $signed(phase_ofs), MAX_STEPS);
`ifdef SDRAM_PHASE_CAL_QUAD_EN
    check("s3_quad", quad, 3);
    check("s3_q90inc_cmds", cmd_cnt[4], 3);
    check("s3_inc_cmds", cmd_cnt[1], 24);
    check("s3_rst_cmds", cmd_cnt[3], 4);
`else
    check("s3_quad", quad, 0);
    check("s3_q90inc_cmds", cmd_cnt[4], 0);
    check("s3_inc_cmds", cmd_cnt[1], 6);
    check("s3_rst_cmds", cmd_cnt[3], 1);
`endif

    // No read data at all.
    run(4, 0);
    check("s4_fail", fail, 1);
    check("s4_fail_code", fail_code, 1);
    check("s4_busy", busy, 0);
    check("s4_step_cmds", cmd_cnt[1] + cmd_cnt[2], 0);
    check("s4_clr_cmds", cmd_cnt[0], 1);

    // Reset during SETTLE, with start pulses while busy and during reset.
    @(negedge sclk0);
    scen = 2;
    clear_counts();
    start = 1'b1;
    @(negedge sclk0);
    start = 1'b1;
    @(negedge sclk0);
    start = 1'b0;
    n = 0;
    while (cmd_cnt[3] == 0 && n < 100) begin
      @(negedge sclk0);
      n++;
    end
    check("s5_rstdcm_seen", cmd_cnt[3], 1);
    @(negedge sclk0);
    check("s5_busy_before_rst", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    clear_counts();
    @(negedge sclk0);
    rst = 1'b0;
    start = 1'b0;
    check("s5_rst_busy", busy, 0);
    check("s5_rst_pre_wcmd", pre_wcmd, 0);
    repeat (40) @(negedge sclk0);
    total = 0;
    for (int i = 0; i < 16; i++) total += cmd_cnt[i];
    check("s5_no_second_run_cmds", total, 0);
    check("s5_no_second_run_busy", {busy, rd_req, done, fail}, 0);

    // Calibration still works after the abort.
    run(2, 0);
    check("s6_done", done, 1);
    check("s6_ofs", $signed(phase_ofs), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
